// File: rtl/zigzag_pkg.sv
// Shared widths, coefficient type and zigzag scan table for the zig_zag reorder stage.
// ZIGZAG_ROW_MAJOR_EN selects row-major input addressing; the default is column-major.
package zigzag_pkg;

   localparam int COEF_W = 11;
   localparam int BLK_N  = 64;

   typedef logic [COEF_W-1:0] coef_t;

   // Entry i is the stored address presented at output position i.
`ifdef ZIGZAG_ROW_MAJOR_EN
   localparam int ZZ [BLK_N] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };
`else
   localparam int ZZ [BLK_N] = '{
       0,  8,  1,  2,  9, 16, 24, 17, 10,  3,  4, 11, 18, 25, 32, 40,
      33, 26, 19, 12,  5,  6, 13, 20, 27, 34, 41, 48, 56, 49, 42, 35,
      28, 21, 14,  7, 15, 22, 29, 36, 43, 50, 57, 58, 51, 44, 37, 30,
      23, 31, 38, 45, 52, 59, 60, 53, 46, 39, 47, 54, 61, 62, 55, 63
   };
`endif

endpackage

// File: rtl/zig_zag_if.sv
// Streaming handshake between the DCT/quantiser, the zigzag stage and the entropy coder.
interface zig_zag_if;
   import zigzag_pkg::*;

   logic  ena_in;
   coef_t in;
   logic  rdy_out;
   logic  ena_out;
   coef_t out;
   logic  rdy_in;

   modport master (
      output ena_in, in, rdy_in,
      input  rdy_out, ena_out, out
   );

   modport slave (
      input  ena_in, in, rdy_in,
      output rdy_out, ena_out, out
   );
endinterface

// File: rtl/zig_zag_bank.sv
// One 64-entry coefficient bank: synchronous write, asynchronous read, contents never reset.
module zigzag_bank
   import zigzag_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_we,
   input  logic [5:0] i_waddr,
   input  coef_t      i_wdata,
   input  logic [5:0] i_raddr,
   output coef_t      o_rdata
);

   coef_t r_mem [BLK_N];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/zig_zag.sv
// Ping-pong zigzag reorder: one bank fills in arrival order while the other drains in scan order.
// ZIGZAG_ROW_MAJOR_EN (in zigzag_pkg) swaps the scan table for row-major input.
module zig_zag
   import zigzag_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   zig_zag_if.slave zz_bus
);

   logic [5:0] r_wr_cnt;
   logic [5:0] r_rd_cnt;
   logic       r_wr_bank;
   logic       r_rd_bank;
   logic [1:0] r_full;

   logic       w_rdy_out;
   logic       w_ena_out;
   logic       w_wr_fire;
   logic       w_rd_fire;
   logic [5:0] w_rd_addr;
   coef_t      w_bank_rdata [2];

   assign w_rdy_out = ~r_full[r_wr_bank];
   assign w_ena_out = r_full[r_rd_bank];
   assign w_wr_fire = zz_bus.ena_in & w_rdy_out;
   assign w_rd_fire = w_ena_out & zz_bus.rdy_in;
   assign w_rd_addr = 6'(ZZ[r_rd_cnt]);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         zigzag_bank u_bank (
            .i_clk   (clk),
            .i_we    (w_wr_fire && (r_wr_bank == 1'(gi))),
            .i_waddr (r_wr_cnt),
            .i_wdata (zz_bus.in),
            .i_raddr (w_rd_addr),
            .o_rdata (w_bank_rdata[gi])
         );
      end
   endgenerate

   // A write only targets an empty bank and a read only a full one, so the two
   // r_full updates below never hit the same bit in one cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         r_full    <= '0;
      end else begin
         if (w_wr_fire) begin
            r_wr_cnt <= r_wr_cnt + 6'd1;
            if (r_wr_cnt == 6'd63) begin
               r_full[r_wr_bank] <= 1'b1;
               r_wr_bank         <= ~r_wr_bank;
            end
         end
         if (w_rd_fire) begin
            r_rd_cnt <= r_rd_cnt + 6'd1;
            if (r_rd_cnt == 6'd63) begin
               r_full[r_rd_bank] <= 1'b0;
               r_rd_bank         <= ~r_rd_bank;
            end
         end
      end
   end

   assign zz_bus.rdy_out = w_rdy_out;
   assign zz_bus.ena_out = w_ena_out;
   assign zz_bus.out     = w_ena_out ? w_bank_rdata[r_rd_bank] : '0;

endmodule

// File: tb/tb_zig_zag.sv
// Directed bench for zig_zag: reset, single block, back-to-back, backpressure, full, mid-stream reset.
module tb_zig_zag;
   import zigzag_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

`ifdef ZIGZAG_ROW_MAJOR_EN
   int zz_exp [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };
`else
   int zz_exp [64] = '{
       0,  8,  1,  2,  9, 16, 24, 17, 10,  3,  4, 11, 18, 25, 32, 40,
      33, 26, 19, 12,  5,  6, 13, 20, 27, 34, 41, 48, 56, 49, 42, 35,
      28, 21, 14,  7, 15, 22, 29, 36, 43, 50, 57, 58, 51, 44, 37, 30,
      23, 31, 38, 45, 52, 59, 60, 53, 46, 39, 47, 54, 61, 62, 55, 63
   };
`endif

   always #5 clk = ~clk;

   zig_zag_if bus_if ();

   zig_zag dut (
      .clk    (clk),
      .rst    (rst),
      .zz_bus (bus_if.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_ena, input int e_val);
      chk({tag, "_ena_out"}, 32'(bus_if.ena_out), 32'(e_ena));
      chk({tag, "_out"}, 32'(bus_if.out), e_val);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed_block(input int base);
      for (int n = 0; n < 64; n++) begin
         bus_if.ena_in = 1'b1;
         bus_if.in     = 11'(base + n);
         tick();
      end
      bus_if.ena_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int j;
      bus_if.ena_in = 1'b0;
      bus_if.in     = '0;
      bus_if.rdy_in = 1'b0;

      // Reset state
      tick();
      tick();
      chk_out("reset", 1'b0, 0);
      chk("reset_rdy_out", 32'(bus_if.rdy_out), 1);
      rst = 1'b1;
      tick();

      // Single block, held with rdy_in low until full
      for (int n = 0; n < 64; n++) begin
         if (n == 63) chk("pre_last_ena_out", 32'(bus_if.ena_out), 0);
         bus_if.ena_in = 1'b1;
         bus_if.in     = 11'(n);
         tick();
      end
      bus_if.ena_in = 1'b0;
      chk_out("first_valid", 1'b1, 0);
      chk("first_rdy_out", 32'(bus_if.rdy_out), 1);
      tick();
      tick();
      chk_out("hold_no_rdy", 1'b1, 0);
      bus_if.rdy_in = 1'b1;
      for (int i = 0; i < 64; i++) begin
         chk_out($sformatf("blk0_%0d", i), 1'b1, zz_exp[i]);
         tick();
      end
      chk_out("blk0_end", 1'b0, 0);

      // Back-to-back blocks with rdy_in held high
      for (int c = 0; c < 192; c++) begin
         if (c == 63) chk_out("b2b_idle", 1'b0, 0);
         if (c == 100) chk("b2b_rdy_out", 32'(bus_if.rdy_out), 1);
         if (c >= 64) begin
            j = c - 64;
            chk_out($sformatf("b2b_%0d", j), 1'b1, (j < 64) ? zz_exp[j] : zz_exp[j-64] + 100);
         end
         bus_if.ena_in = (c < 128);
         bus_if.in     = (c < 64) ? 11'(c) : 11'(c + 36);
         tick();
      end
      chk_out("b2b_end", 1'b0, 0);

      // Backpressure: rdy_in toggles every cycle
      bus_if.rdy_in = 1'b0;
      feed_block(200);
      j = 0;
      for (int c = 0; c < 200 && j < 64; c++) begin
         bus_if.rdy_in = c[0];
         chk_out($sformatf("bp_%0d", j), 1'b1, zz_exp[j] + 200);
         tick();
         if (bus_if.rdy_in) j++;
      end
      chk("bp_count", 32'(j), 64);
      bus_if.rdy_in = 1'b0;
      chk_out("bp_end", 1'b0, 0);

      // Full: third block is dropped while both banks hold data
      for (int c = 0; c < 192; c++) begin
         if (c == 127) chk("full_rdy_before", 32'(bus_if.rdy_out), 1);
         if (c == 128) chk("full_rdy_after", 32'(bus_if.rdy_out), 0);
         bus_if.ena_in = 1'b1;
         bus_if.in     = 11'(300 + c);
         tick();
      end
      bus_if.ena_in = 1'b0;
      chk("full_rdy_hold", 32'(bus_if.rdy_out), 0);
      bus_if.rdy_in = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (i == 63) chk("full_rdy_last", 32'(bus_if.rdy_out), 0);
         chk_out($sformatf("full_a_%0d", i), 1'b1, zz_exp[i] + 300);
         tick();
      end
      chk("full_rdy_freed", 32'(bus_if.rdy_out), 1);
      for (int i = 0; i < 64; i++) begin
         chk_out($sformatf("full_b_%0d", i), 1'b1, zz_exp[i] + 364);
         tick();
      end
      chk_out("full_end", 1'b0, 0);

      // Reset after 30 outputs of a block
      bus_if.rdy_in = 1'b0;
      feed_block(500);
      bus_if.rdy_in = 1'b1;
      for (int i = 0; i < 30; i++) begin
         chk_out($sformatf("pre_rst_%0d", i), 1'b1, zz_exp[i] + 500);
         tick();
      end
      rst = 1'b0;
      tick();
      chk_out("mid_rst", 1'b0, 0);
      chk("mid_rst_rdy_out", 32'(bus_if.rdy_out), 1);
      rst = 1'b1;
      for (int n = 0; n < 64; n++) begin
         if (n == 40) chk_out("post_rst_fill", 1'b0, 0);
         bus_if.ena_in = 1'b1;
         bus_if.in     = 11'(n);
         tick();
      end
      bus_if.ena_in = 1'b0;
      for (int i = 0; i < 64; i++) begin
         chk_out($sformatf("post_rst_%0d", i), 1'b1, zz_exp[i]);
         tick();
      end
      chk_out("post_rst_end", 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
